dac_sample_transmitter: RTL and testbench
=========================================

DAC_SAMPLE_TRANSMITTER -- requirements
Module: dac_sample_transmitter

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4; system clocks per SCK half-period, legal range 1..255.
REQ-002 SHALL have parameter DAC_CONFIG, default 4'b0011; DAC command nibble (channel A, unbuffered, 1x gain, active).
REQ-003 SHALL have port inClock  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port inReset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port inSample  input  12  unsigned sample from the envelope stage.
REQ-006 SHALL have port inSampleReady  input  1  one-cycle strobe; inSample is valid in this cycle.
REQ-007 SHALL have port outBusy  output  1  high while a frame is in progress.
REQ-008 SHALL have port outDropped  output  1  one-cycle pulse when a pending sample is overwritten.
REQ-009 SHALL have port outDacCsN  output  1  DAC chip select, active-low.
REQ-010 SHALL have port outDacSck  output  1  serial clock, idle low.
REQ-011 SHALL have port outDacSdi  output  1  serial data, MSB first.
REQ-012 SHALL have port outDacLdacN  output  1  DAC latch strobe, active-low.

Function
REQ-013 SHALL use states IDLE, SHIFT, CS_HOLD, LDAC and return to IDLE.
REQ-014 SHALL transmit the frame word {DAC_CONFIG, sample[11:0]}, 16 bits, MSB first.
REQ-015 In IDLE with inSampleReady high, or with pending valid, SHALL load the frame word and enter SHIFT on the next edge.
REQ-016 On that edge SHALL drive outDacCsN low and outBusy high.
REQ-017 SHALL send each bit in 2*CLK_DIV cycles: CLK_DIV cycles SCK low with SDI stable, then CLK_DIV cycles SCK high.
REQ-018 SHALL change SDI only while SCK is low.
REQ-019 After bit 0's high phase, SHALL stay in CS_HOLD for CLK_DIV cycles with SCK low and CS low.
REQ-020 SHALL then drive CS high and LDAC low for CLK_DIV cycles (LDAC state), then enter IDLE with LDAC high.
REQ-021 SHALL keep outBusy high from the SHIFT entry edge until the IDLE entry edge: 34*CLK_DIV cycles.
REQ-022 With inSampleReady while busy, SHALL capture inSample into a one-entry pending register.
REQ-023 If pending is already valid when a new sample is captured, SHALL overwrite it (newest wins) and pulse outDropped for one cycle.
REQ-024 On IDLE entry with pending valid, SHALL start the pending frame on the next edge and clear pending.
REQ-025 On inSampleReady coinciding with pending consumption, SHALL transmit the pending sample and hold the new one as pending.
REQ-026 SHALL not change the frame word mid-frame; the frame is fixed at its start edge.
REQ-027 SHALL keep SCK low and SDI 0 whenever CS is high.

Reset
REQ-028 On inReset high at a clock edge, SHALL enter IDLE and clear pending and all counters, regardless of state.
REQ-029 On reset, outputs SHALL be: outDacCsN=1, outDacSck=0, outDacSdi=0, outDacLdacN=1, outBusy=0, outDropped=0.
REQ-030 Reset mid-frame SHALL abort the frame without an LDAC pulse.

Structure
REQ-031 The shared synth package SHALL hold the state encoding, the default DAC_CONFIG, and the frame width 16.
REQ-032 SHALL contain one sub-module, spi_tick_gen, which generates the CLK_DIV half-period tick and is restarted at frame start.

Verification
REQ-033 CLK_DIV=4, strobe with 0xABC -> SDI sequence 0x3ABC on SCK rising edges; busy for 136 cycles; one LDAC low pulse of 4 cycles.
REQ-034 Strobe 0x123, then 0x456 at cycle 50 -> two frames 0x3123 and 0x3456; the second frame's CS falls 1 cycle after the first's IDLE entry; no outDropped.
REQ-035 Strobe 0x001, then 0x002 and 0x003 mid-frame -> frames 0x3001 and 0x3003 only; exactly one outDropped pulse, on the 0x003 strobe.
REQ-036 inReset asserted at cycle 60 of a frame -> next edge CS=1, SCK=0, busy=0, no LDAC pulse; a new strobe then sends a full frame.
REQ-037 CLK_DIV=1, strobe 0xFFF -> frame 0x3FFF; SCK period 2 cycles; busy 34 cycles.

Source files
------------

// File: rtl/dac_sample_transmitter_pkg.sv
// Shared definitions for the DAC sample transmitter: FSM encoding,
// frame geometry and the default DAC command nibble.
package dac_sample_transmitter_pkg;

  localparam int SAMPLE_W = 12;
  localparam int CFG_W    = 4;
  localparam int FRAME_W  = 16;

  // Channel A, unbuffered reference, 1x gain, output active.
  localparam logic [CFG_W-1:0] DAC_CONFIG_DEFAULT = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_CS_HOLD = 2'd2,
    ST_LDAC    = 2'd3
  } state_e;

  // Assemble the 16-bit word sent to the DAC, command nibble first.
  function automatic logic [FRAME_W-1:0] build_frame(
    input logic [CFG_W-1:0]    cfg,
    input logic [SAMPLE_W-1:0] sample
  );
    return {cfg, sample};
  endfunction

endpackage

// File: rtl/dac_sample_transmitter_if.sv
// Sample-input and DAC-pin bundle of the transmitter. The slave side is the
// transmitter itself; the master side feeds samples and watches the pins.
interface dac_sample_transmitter_if;
  import dac_sample_transmitter_pkg::*;

  logic [SAMPLE_W-1:0] inSample;
  logic                inSampleReady;
  logic                outBusy;
  logic                outDropped;
  logic                outDacCsN;
  logic                outDacSck;
  logic                outDacSdi;
  logic                outDacLdacN;

  modport master (
    output inSample, inSampleReady,
    input  outBusy, outDropped, outDacCsN, outDacSck, outDacSdi, outDacLdacN
  );

  modport slave (
    input  inSample, inSampleReady,
    output outBusy, outDropped, outDacCsN, outDacSck, outDacSdi, outDacLdacN
  );

endinterface

// File: rtl/dac_sample_transmitter_spi_tick_gen.sv
// Half-period tick for the DAC serial clock. The counter sits at zero while
// the transmitter is idle and is forced back to zero on the frame start edge,
// so every frame begins with a full CLK_DIV-cycle low phase.
module spi_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam logic [7:0] LAST_CNT = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: hold at zero when idle or restarting, wrap on the last count.
  always_comb begin
    cnt_d = cnt_q;
    if (restart_i || !en_i) begin
      cnt_d = 8'd0;
    end else if (cnt_q == LAST_CNT) begin
      cnt_d = 8'd0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/dac_sample_transmitter.sv
// Serialises 12-bit samples to an SPI DAC as {DAC_CONFIG, sample} frames,
// then pulses LDAC. A one-entry pending register absorbs a sample arriving
// mid-frame; a newer one overwrites it and raises outDropped for a cycle.
module dac_sample_transmitter
  import dac_sample_transmitter_pkg::*;
#(
  parameter int               CLK_DIV    = 4,
  parameter logic [CFG_W-1:0] DAC_CONFIG = DAC_CONFIG_DEFAULT
) (
  input  logic                     inClock,
  input  logic                     inReset,
  dac_sample_transmitter_if.slave  bus
);

  state_e              state_q, state_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic                sck_q, sck_d;
  logic                sdi_q, sdi_d;
  logic                csn_q, csn_d;
  logic                ldacn_q, ldacn_d;
  logic                busy_q, busy_d;
  logic                dropped_q, dropped_d;
  logic                pend_valid_q, pend_valid_d;
  logic [SAMPLE_W-1:0] pend_q, pend_d;

  logic                start_s;
  logic                tick_s;
  logic                run_s;
  logic [SAMPLE_W-1:0] sample_sel_s;
  logic [FRAME_W-1:0]  new_word_s;

  // A waiting sample always goes out before the one strobed in this cycle.
  assign sample_sel_s = pend_valid_q ? pend_q : bus.inSample;
  assign new_word_s   = build_frame(DAC_CONFIG, sample_sel_s);
  assign run_s        = (state_q != ST_IDLE);

  spi_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk_i     (inClock),
    .rst_i     (inReset),
    .en_i      (run_s),
    .restart_i (start_s),
    .tick_o    (tick_s)
  );

  // Frame sequencer: next state and next values of all DAC pins.
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    sck_d     = sck_q;
    sdi_d     = sdi_q;
    csn_d     = csn_q;
    ldacn_d   = ldacn_q;
    busy_d    = busy_q;
    start_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.inSampleReady || pend_valid_q) begin
          start_s   = 1'b1;
          frame_d   = new_word_s;
          bit_cnt_d = 4'd15;
          sdi_d     = new_word_s[FRAME_W-1];
          sck_d     = 1'b0;
          csn_d     = 1'b0;
          ldacn_d   = 1'b1;
          busy_d    = 1'b1;
          state_d   = ST_SHIFT;
        end else begin
          sck_d   = 1'b0;
          sdi_d   = 1'b0;
          csn_d   = 1'b1;
          ldacn_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (tick_s) begin
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            // Falling edge: SDI moves only together with SCK going low.
            sck_d = 1'b0;
            if (bit_cnt_q == 4'd0) begin
              sdi_d   = 1'b0;
              state_d = ST_CS_HOLD;
            end else begin
              bit_cnt_d = bit_cnt_q - 4'd1;
              frame_d   = {frame_q[FRAME_W-2:0], 1'b0};
              sdi_d     = frame_q[FRAME_W-2];
            end
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_CS_HOLD: begin
        if (tick_s) begin
          csn_d   = 1'b1;
          ldacn_d = 1'b0;
          sck_d   = 1'b0;
          sdi_d   = 1'b0;
          state_d = ST_LDAC;
        end else begin
          state_d = ST_CS_HOLD;
        end
      end
      ST_LDAC: begin
        if (tick_s) begin
          ldacn_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LDAC;
        end
      end
      default: begin
        state_d = ST_IDLE;
        sck_d   = 1'b0;
        sdi_d   = 1'b0;
        csn_d   = 1'b1;
        ldacn_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Pending slot: capture while busy, newest wins, consumed on frame start.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_d       = pend_q;
    dropped_d    = 1'b0;
    if (state_q == ST_IDLE) begin
      if (pend_valid_q) begin
        // Pending sample leaves now; a coinciding strobe takes its place.
        pend_valid_d = bus.inSampleReady;
        pend_d       = bus.inSampleReady ? bus.inSample : pend_q;
      end else begin
        pend_valid_d = 1'b0;
      end
    end else if (bus.inSampleReady) begin
      pend_valid_d = 1'b1;
      pend_d       = bus.inSample;
      dropped_d    = pend_valid_q;
    end else begin
      pend_valid_d = pend_valid_q;
    end
  end

  // State and output registers; reset aborts any frame without an LDAC pulse.
  always_ff @(posedge inClock) begin
    if (inReset) begin
      state_q      <= ST_IDLE;
      frame_q      <= '0;
      bit_cnt_q    <= 4'd0;
      sck_q        <= 1'b0;
      sdi_q        <= 1'b0;
      csn_q        <= 1'b1;
      ldacn_q      <= 1'b1;
      busy_q       <= 1'b0;
      dropped_q    <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      bit_cnt_q    <= bit_cnt_d;
      sck_q        <= sck_d;
      sdi_q        <= sdi_d;
      csn_q        <= csn_d;
      ldacn_q      <= ldacn_d;
      busy_q       <= busy_d;
      dropped_q    <= dropped_d;
      pend_valid_q <= pend_valid_d;
      pend_q       <= pend_d;
    end
  end

  assign bus.outBusy     = busy_q;
  assign bus.outDropped  = dropped_q;
  assign bus.outDacCsN   = csn_q;
  assign bus.outDacSck   = sck_q;
  assign bus.outDacSdi   = sdi_q;
  assign bus.outDacLdacN = ldacn_q;

endmodule

// File: tb/tb_dac_sample_transmitter.sv
// Directed bench: two transmitters (CLK_DIV=4 and CLK_DIV=1) watched by a
// pin-level monitor that rebuilds frames from SCK rising edges.
module tb_dac_sample_transmitter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dac_sample_transmitter_if bus0 ();
  dac_sample_transmitter_if bus1 ();

  dac_sample_transmitter #(.CLK_DIV(4)) dut0 (
    .inClock (clk),
    .inReset (rst),
    .bus     (bus0.slave)
  );

  dac_sample_transmitter #(.CLK_DIV(1)) dut1 (
    .inClock (clk),
    .inReset (rst),
    .bus     (bus1.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [1:0] csn_v, sck_v, sdi_v, ldacn_v, busy_v, drop_v;
  assign csn_v   = {bus1.outDacCsN,   bus0.outDacCsN};
  assign sck_v   = {bus1.outDacSck,   bus0.outDacSck};
  assign sdi_v   = {bus1.outDacSdi,   bus0.outDacSdi};
  assign ldacn_v = {bus1.outDacLdacN, bus0.outDacLdacN};
  assign busy_v  = {bus1.outBusy,     bus0.outBusy};
  assign drop_v  = {bus1.outDropped,  bus0.outDropped};

  // Monitor state, written only by the monitor process.
  int          cyc = 0;
  logic [1:0]  csn_p = 2'b11, sck_p = 2'b00, sdi_p = 2'b00, ldacn_p = 2'b11, busy_p = 2'b00;
  logic [15:0] word_r [2] = '{16'h0, 16'h0};
  int          nbits [2] = '{0, 0};
  logic [15:0] frames [2][32];
  int          fbits  [2][32];
  int          nfr [2] = '{0, 0};
  int          busy_run [2] = '{0, 0};
  int          busy_len [2] = '{0, 0};
  int          idle_cyc [2] = '{0, 0};
  int          cs_gap [2] = '{0, 0};
  int          ldac_run [2] = '{0, 0};
  int          ldac_len [2] = '{0, 0};
  int          ldac_pulses [2] = '{0, 0};
  int          drops [2] = '{0, 0};
  int          viol = 0;

  // Pin monitor sampled on the falling clock edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (!csn_v[d] && sck_v[d] && !sck_p[d]) begin
        word_r[d] <= {word_r[d][14:0], sdi_v[d]};
        nbits[d]  <= nbits[d] + 1;
      end
      if (csn_p[d] && !csn_v[d]) begin
        word_r[d] <= 16'h0;
        nbits[d]  <= 0;
        cs_gap[d] <= cyc - idle_cyc[d];
      end
      if (!csn_p[d] && csn_v[d]) begin
        frames[d][nfr[d] % 32] <= word_r[d];
        fbits[d][nfr[d] % 32]  <= nbits[d];
        nfr[d] <= nfr[d] + 1;
      end
      busy_run[d] <= busy_v[d] ? busy_run[d] + 1 : 0;
      if (busy_p[d] && !busy_v[d]) begin
        busy_len[d] <= busy_run[d];
        idle_cyc[d] <= cyc;
      end
      ldac_run[d] <= !ldacn_v[d] ? ldac_run[d] + 1 : 0;
      if (!ldacn_p[d] && ldacn_v[d]) begin
        ldac_len[d]    <= ldac_run[d];
        ldac_pulses[d] <= ldac_pulses[d] + 1;
      end
      if (drop_v[d]) drops[d] <= drops[d] + 1;
      if (csn_v[d] && (sck_v[d] || sdi_v[d])) viol <= viol + 1;
      if (sck_p[d] && sck_v[d] && (sdi_v[d] != sdi_p[d])) viol <= viol + 1;
    end
    csn_p   <= csn_v;
    sck_p   <= sck_v;
    sdi_p   <= sdi_v;
    ldacn_p <= ldacn_v;
    busy_p  <= busy_v;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input int d, input logic [11:0] s);
    if (d == 0) begin
      bus0.inSample = s; bus0.inSampleReady = 1'b1;
    end else begin
      bus1.inSample = s; bus1.inSampleReady = 1'b1;
    end
    tick(1);
    bus0.inSampleReady = 1'b0;
    bus1.inSampleReady = 1'b0;
  endtask

  task automatic wait_frames(input int d, input int target, input int limit);
    int n = 0;
    while (nfr[d] < target && n < limit) begin
      tick(1);
      n++;
    end
    check("frame_arrival", 32'(nfr[d]), 32'(target));
  endtask

  task automatic wait_idle(input int d, input int limit);
    int n = 0;
    while (busy_v[d] && n < limit) begin
      tick(1);
      n++;
    end
    check("idle_reached", 32'(busy_v[d]), 32'd0);
  endtask

  function automatic logic [5:0] pins(input int d);
    return {csn_v[d], sck_v[d], sdi_v[d], ldacn_v[d], busy_v[d], drop_v[d]};
  endfunction

  typedef struct {
    int          dut;
    logic [11:0] sample;
    logic [15:0] exp_frame;
    int          exp_busy;
    int          exp_ldac;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bf, bl, bd;
    vecs[0] = '{0, 12'hABC, 16'h3ABC, 136, 4};
    vecs[1] = '{0, 12'h000, 16'h3000, 136, 4};
    vecs[2] = '{0, 12'hFFF, 16'h3FFF, 136, 4};
    vecs[3] = '{0, 12'h555, 16'h3555, 136, 4};
    vecs[4] = '{1, 12'hFFF, 16'h3FFF, 34, 1};
    vecs[5] = '{1, 12'h5A5, 16'h35A5, 34, 1};

    rst = 1'b1;
    bus0.inSample = 12'h0; bus0.inSampleReady = 1'b0;
    bus1.inSample = 12'h0; bus1.inSampleReady = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_pins_div4", 32'(pins(0)), 32'b100100);
    check("reset_pins_div1", 32'(pins(1)), 32'b100100);
    rst = 1'b0;
    tick(2);

    // Single frames from the vector table.
    for (int i = 0; i < 6; i++) begin
      int d;
      d  = vecs[i].dut;
      bf = nfr[d]; bl = ldac_pulses[d]; bd = drops[d];
      strobe(d, vecs[i].sample);
      wait_frames(d, bf + 1, 400);
      wait_idle(d, 50);
      tick(2);
      check("frame_word", 32'(frames[d][bf % 32]), 32'(vecs[i].exp_frame));
      check("frame_bits", 32'(fbits[d][bf % 32]), 32'd16);
      check("busy_len",   32'(busy_len[d]), 32'(vecs[i].exp_busy));
      check("ldac_len",   32'(ldac_len[d]), 32'(vecs[i].exp_ldac));
      check("ldac_count", 32'(ldac_pulses[d] - bl), 32'd1);
      check("no_drop",    32'(drops[d] - bd), 32'd0);
    end

    // Back-to-back: second sample waits as pending, starts right after IDLE.
    bf = nfr[0]; bl = ldac_pulses[0]; bd = drops[0];
    strobe(0, 12'h123);
    tick(49);
    strobe(0, 12'h456);
    wait_frames(0, bf + 2, 600);
    wait_idle(0, 50);
    tick(2);
    check("b2b_frame0", 32'(frames[0][bf % 32]), 32'h3123);
    check("b2b_frame1", 32'(frames[0][(bf + 1) % 32]), 32'h3456);
    check("b2b_cs_gap", 32'(cs_gap[0]), 32'd1);
    check("b2b_ldac",   32'(ldac_pulses[0] - bl), 32'd2);
    check("b2b_nodrop", 32'(drops[0] - bd), 32'd0);

    // Overwrite: 0x002 is replaced by 0x003 while the first frame runs.
    bf = nfr[0]; bd = drops[0];
    strobe(0, 12'h001);
    tick(19);
    strobe(0, 12'h002);
    tick(19);
    strobe(0, 12'h003);
    wait_frames(0, bf + 2, 600);
    wait_idle(0, 50);
    tick(150);
    check("ovw_frame0", 32'(frames[0][bf % 32]), 32'h3001);
    check("ovw_frame1", 32'(frames[0][(bf + 1) % 32]), 32'h3003);
    check("ovw_count",  32'(nfr[0] - bf), 32'd2);
    check("ovw_drops",  32'(drops[0] - bd), 32'd1);

    // Reset mid-frame, with a sample pending that must be discarded.
    bl = ldac_pulses[0];
    strobe(0, 12'h7E7);
    tick(29);
    strobe(0, 12'h111);
    tick(29);
    rst = 1'b1;
    tick(1);
    check("midrst_pins", 32'(pins(0)), 32'b100100);
    rst = 1'b0;
    tick(20);
    check("midrst_idle",    32'(busy_v[0]), 32'd0);
    check("midrst_no_ldac", 32'(ldac_pulses[0] - bl), 32'd0);
    bf = nfr[0]; bl = ldac_pulses[0];
    strobe(0, 12'h2C4);
    wait_frames(0, bf + 1, 400);
    wait_idle(0, 50);
    tick(2);
    check("postrst_frame", 32'(frames[0][bf % 32]), 32'h32C4);
    check("postrst_bits",  32'(fbits[0][bf % 32]), 32'd16);
    check("postrst_ldac",  32'(ldac_pulses[0] - bl), 32'd1);

    check("pin_rules", 32'(viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
